// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop RX synchronizer, mid-bit sampling FSM and a
// one-deep holding register with valid/ready handshake, framing-error and overrun pulses.
module uart_rx_os #(
  parameter int clk_reduction = 64,
  parameter int word_width    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RX,
  output logic [word_width-1:0] R_W,
  output logic                  valid,
  input  logic                  ready,
  output logic                  R_locked,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int TW = $clog2(clk_reduction);
  localparam int CW = $clog2(word_width + 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(clk_reduction / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(clk_reduction - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(word_width - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  rx_meta_q, rx_meta_d;
  logic                  rxs_q, rxs_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [CW-1:0]         bitcnt_q, bitcnt_d;
  logic [word_width-1:0] shift_q, shift_d;
  logic                  deliver_q, deliver_d;
  logic [word_width-1:0] rw_q, rw_d;
  logic                  valid_q, valid_d;
  logic                  locked_q, locked_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;

  // Synchronizer inputs
  always_comb begin
    rx_meta_d = RX;
    rxs_d     = rx_meta_q;
  end

  // Frame FSM: start validation at half-bit, then one sample per bit period
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    deliver_d = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d  = '0;
        bitcnt_d = '0;
        if (!rxs_q) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (timer_q == HALF_M1) begin
          timer_d = '0;
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          timer_d = timer_q + TW'(1'b1);
        end
      end
      S_DATA: begin
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          shift_d = {rxs_q, shift_q[word_width-1:1]};
          if (bitcnt_q == LAST_BIT) begin
            bitcnt_d = '0;
            state_d  = S_STOP;
          end else begin
            bitcnt_d = bitcnt_q + CW'(1'b1);
          end
        end else begin
          timer_d = timer_q + TW'(1'b1);
        end
      end
      S_STOP: begin
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          if (rxs_q) begin
            deliver_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          timer_d = timer_q + TW'(1'b1);
        end
      end
      S_BREAK: begin
        // A held-low line reports its framing error once, then waits for idle
        if (rxs_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BREAK;
        end
      end
      default: begin
        state_d  = S_IDLE;
        timer_d  = '0;
        bitcnt_d = '0;
      end
    endcase
    locked_d = (state_d != S_IDLE);
  end

  // Holding register: the word lands one cycle after the stop sample
  always_comb begin
    rw_d    = rw_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (deliver_q) begin
      if (valid_q && !ready) begin
        ovr_d = 1'b1;
      end else begin
        rw_d    = shift_q;
        valid_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      deliver_q <= 1'b0;
      rw_q      <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rxs_q     <= rxs_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      deliver_q <= deliver_d;
      rw_q      <= rw_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign R_W       = rw_q;
  assign valid     = valid_q;
  assign R_locked  = locked_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: frame-level timeline model (edge numbers of lock, stop sample
// and delivery derived from the bit-time arithmetic) checked against the DUT every cycle.
module tb_uart_rx_os;
  localparam int CR   = 16;
  localparam int W    = 8;
  localparam int SYNC = 3;  // RX driven after edge k is first seen by the FSM at edge k+3

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         RX = 1'b1;
  logic         ready = 1'b0;
  logic [W-1:0] R_W;
  logic         valid, R_locked, frame_err, overrun;

  uart_rx_os #(.clk_reduction(CR), .word_width(W)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .R_W(R_W), .valid(valid), .ready(ready),
    .R_locked(R_locked), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  logic [W-1:0] m_rw = '0;
  bit m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0, m_locked = 1'b0;
  logic [W-1:0] dlv[int];
  bit ferr_at[int];
  int lk_lo[$];
  int lk_hi[$];

  bit rnd_ready = 1'b0;
  bit ready_set = 1'b0;
  int ready_pulse = -1;
  int ferr_cnt = 0, ovr_cnt = 0, valid_rise = -1;
  bit prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Edge counter and behavioural model of the outputs after each edge
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    if (!rst_n) begin
      m_rw = '0; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_locked = 1'b0;
    end else begin
      m_ferr = ferr_at.exists(cyc);
      m_ovr  = 1'b0;
      if (dlv.exists(cyc)) begin
        if (m_valid && !ready) m_ovr = 1'b1;
        else begin
          m_rw = dlv[cyc];
          m_valid = 1'b1;
        end
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
      m_locked = 1'b0;
      foreach (lk_lo[i]) if (cyc >= lk_lo[i] && cyc < lk_hi[i]) m_locked = 1'b1;
    end
  end

  // Consumer: random, held level, or a single pulse sampled at edge ready_pulse+1
  initial forever begin
    @(posedge clk);
    #2;
    ready = rnd_ready ? 1'($urandom) : (ready_set || cyc == ready_pulse);
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_rw", {24'd0, R_W}, 32'd0);
      chk("rst_locked", {31'd0, R_locked}, 32'd0);
      chk("rst_ferr", {31'd0, frame_err}, 32'd0);
      chk("rst_ovr", {31'd0, overrun}, 32'd0);
    end else begin
      chk("valid", {31'd0, valid}, {31'd0, m_valid});
      chk("rw", {24'd0, R_W}, {24'd0, m_rw});
      chk("locked", {31'd0, R_locked}, {31'd0, m_locked});
      chk("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
      chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    end
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (valid && !prev_valid) valid_rise = cyc;
    prev_valid = valid;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame starting now; a bad stop bit leaves RX low until release_break
  task automatic send_frame(input logic [W-1:0] w, input bit stop_ok, input bit pulse_at_stop);
    int t, s;
    t = cyc + SYNC;
    s = t + CR / 2 + (W + 1) * CR;
    lk_lo.push_back(t);
    if (stop_ok) begin
      dlv[s + 1] = w;
      lk_hi.push_back(s);
    end else begin
      ferr_at[s] = 1'b1;
      lk_hi.push_back(32'h7fffffff);
    end
    if (pulse_at_stop) ready_pulse = s;
    RX = 1'b0;
    tick(CR);
    for (int i = 0; i < W; i++) begin
      RX = w[i];
      tick(CR);
    end
    RX = stop_ok;
    tick(CR);
  endtask

  task automatic release_break();
    RX = 1'b1;
    lk_hi[lk_hi.size() - 1] = cyc + SYNC;
  endtask

  initial begin
    int k, c0, f0;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    chk("post_reset_valid", {31'd0, valid}, 32'd0);
    chk("post_reset_rw", {24'd0, R_W}, 32'd0);
    chk("post_reset_locked", {31'd0, R_locked}, 32'd0);

    // Single frame with consumer always ready: latency 3 + 8 + 9*16 + 1
    ready_set = 1'b1;
    k = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(CR);
    chk("a5_latency", valid_rise - k, 32'd156);
    chk("a5_rw", {24'd0, R_W}, 32'h0000_00A5);
    chk("a5_valid_gone", {31'd0, valid}, 32'd0);

    // Back-to-back frames with no consumer: second one overruns
    ready_set = 1'b0;
    c0 = ovr_cnt;
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    tick(4);
    chk("ovr_rw", {24'd0, R_W}, 32'h0000_003C);
    chk("ovr_valid", {31'd0, valid}, 32'd1);
    chk("ovr_count", ovr_cnt - c0, 32'd1);
    ready_pulse = cyc;
    tick(3);
    chk("ovr_consumed", {31'd0, valid}, 32'd0);

    // Short low glitch is rejected at the half-bit check
    f0 = ferr_cnt;
    k = cyc;
    lk_lo.push_back(k + SYNC);
    lk_hi.push_back(k + SYNC + CR / 2);
    RX = 1'b0;
    tick(CR / 4);
    RX = 1'b1;
    tick(CR);
    chk("glitch_locked", {31'd0, R_locked}, 32'd0);
    chk("glitch_ferr", ferr_cnt - f0, 32'd0);
    chk("glitch_valid", {31'd0, valid}, 32'd0);

    // Bad stop bit followed by a held-low line
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    tick(3 * CR);
    chk("break_locked", {31'd0, R_locked}, 32'd1);
    release_break();
    tick(CR);
    chk("break_ferr_once", ferr_cnt - f0, 32'd1);
    chk("break_idle", {31'd0, R_locked}, 32'd0);
    chk("break_valid", {31'd0, valid}, 32'd0);

    // Reset in the middle of bit 4 of 0xFF, then a clean 0x12
    ready_set = 1'b1;
    k = cyc;
    lk_lo.push_back(k + SYNC);
    lk_hi.push_back(k + SYNC + CR / 2 + (W + 1) * CR);
    dlv[k + SYNC + CR / 2 + (W + 1) * CR + 1] = 8'hFF;
    RX = 1'b0;
    tick(CR);
    RX = 1'b1;
    tick(4 * CR + CR / 2);
    rst_n = 1'b0;
    dlv.delete();
    ferr_at.delete();
    lk_lo.delete();
    lk_hi.delete();
    tick(3);
    rst_n = 1'b1;
    tick(2 * CR);
    chk("abort_valid", {31'd0, valid}, 32'd0);
    send_frame(8'h12, 1'b1, 1'b0);
    tick(CR);
    chk("after_reset_rw", {24'd0, R_W}, 32'h0000_0012);

    // Second word lands on the very cycle the first is consumed
    ready_set = 1'b0;
    c0 = ovr_cnt;
    send_frame(8'h5A, 1'b1, 1'b0);
    send_frame(8'hA7, 1'b1, 1'b1);
    tick(4);
    chk("swap_rw", {24'd0, R_W}, 32'h0000_00A7);
    chk("swap_valid", {31'd0, valid}, 32'd1);
    chk("swap_no_ovr", ovr_cnt - c0, 32'd0);
    ready_pulse = cyc;
    tick(3);

    // Randomised frames, stop bits, gaps and consumer behaviour
    rnd_ready = 1'b1;
    for (int n = 0; n < 25; n++) begin
      logic [W-1:0] w;
      bit ok;
      w  = W'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      send_frame(w, ok, 1'b0);
      if (ok) begin
        tick($urandom_range(0, CR));
      end else begin
        tick($urandom_range(0, 2 * CR));
        release_break();
        tick($urandom_range(1, CR));
      end
    end
    rnd_ready = 1'b0;
    tick(2 * CR);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
